// File: rtl/abro_pkg.sv
// Shared constants and types for the ABRO front end and its state machine.
package abro_pkg;

   // Default number of consecutive synchronized cycles a new input value must hold.
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

   // Number of conditioned input channels (A, B, R).
   localparam int unsigned NUM_CH = 3;

   // Channel index, also used as the bit position in per-channel vectors.
   typedef enum logic [1:0] {
      CH_A = 2'd0,
      CH_B = 2'd1,
      CH_R = 2'd2
   } abro_ch_e;

endpackage

// File: rtl/abro_debounce_ch.sv
// One input channel: 2-FF synchronizer, N-cycle debouncer and rising-edge detector.
module abro_debounce_ch
   import abro_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse_raw
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // A single-cycle debounce window would make the counter zero bits wide.
   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
         $error("abro_debounce_ch: DEBOUNCE_CYCLES must be 2 or more");
      end
   endgenerate

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             pulse_q;
   logic             pulse_d;

   // Two-stage synchronizer; only sync2_q is used downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive cycles of disagreement; accept the new value once the run is long enough.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      pulse_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            // Only an accepted 0->1 transition produces a pulse.
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce counter, accepted level and edge pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign level     = level_q;
   assign pulse_raw = pulse_q;

endmodule

// File: rtl/abro_input_conditioner.sv
// Conditions raw A/B/R inputs into clean levels and single-cycle pulses; R wins coincident events.
module abro_input_conditioner
   import abro_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw,
   input  logic b_raw,
   input  logic r_raw,
   output logic a_pulse,
   output logic b_pulse,
   output logic r_pulse,
   output logic a_level,
   output logic b_level,
   output logic r_level
);

   logic [NUM_CH-1:0] raw_vec;
   logic [NUM_CH-1:0] level_vec;
   logic [NUM_CH-1:0] pulse_raw_vec;

   assign raw_vec[CH_A] = a_raw;
   assign raw_vec[CH_B] = b_raw;
   assign raw_vec[CH_R] = r_raw;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      abro_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .raw       (raw_vec[ch]),
         .level     (level_vec[ch]),
         .pulse_raw (pulse_raw_vec[ch])
      );
   end

   // A/B events coincident with an R event are dropped, not deferred; levels pass unmasked.
   assign r_pulse = pulse_raw_vec[CH_R];
   assign a_pulse = pulse_raw_vec[CH_A] & ~pulse_raw_vec[CH_R];
   assign b_pulse = pulse_raw_vec[CH_B] & ~pulse_raw_vec[CH_R];

   assign a_level = level_vec[CH_A];
   assign b_level = level_vec[CH_B];
   assign r_level = level_vec[CH_R];

endmodule
